// File: rtl/dflow_tuple_unpacker.sv
// Buffers 144-bit QDR burst words, unpacks them into five-tuple/length records, paces them by
// the embedded gap and detects end-of-trace. Build macro TUPLE_LEN_CHECK_EN adds a length filter.
module dflow_tuple_unpacker #(
    parameter int FIFO_DATA_WIDTH    = 144,
    parameter int PKT_TUPLE_WIDTH    = 104,
    parameter int PKT_LEN_WIDTH      = 16,
    parameter int GAP_WIDTH          = 22,
    parameter int FIFO_DEPTH_BITS    = 4,
    parameter int NEARLY_FULL_MARGIN = 4,
    parameter int COUNT_WIDTH        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst,
    input  logic                       fifo_wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic                       fifo_nearly_full,
    output logic [PKT_TUPLE_WIDTH-1:0] fivetuple_data_out,
    output logic [PKT_LEN_WIDTH-1:0]   pkt_len_out,
    output logic                       tuple_out_vld,
    input  logic                       tuple_out_ready,
    output logic                       replay_done,
    output logic [COUNT_WIDTH-1:0]     tuple_count,
    output logic [COUNT_WIDTH-1:0]     drop_count,
    output logic [COUNT_WIDTH-1:0]     len_err_count
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int OCC_W   = FIFO_DEPTH_BITS + 1;
    localparam int LEN_LO  = PKT_TUPLE_WIDTH;
    localparam int GAP_LO  = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
    localparam int EOT_BIT = GAP_LO + GAP_WIDTH;
    localparam int VLD_BIT = EOT_BIT + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_PRESENT,
        S_DONE
    } state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic srst;
    assign srst = rst | sw_rst;

    state_t state_reg;

    // ------------------------------------------------------------------
    // Word FIFO: array storage with a registered read port
    // ------------------------------------------------------------------
    logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_DATA_WIDTH-1:0] rd_data_reg;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [OCC_W-1:0]           occ_reg;
    logic [OCC_W-1:0]           occ_next;
    logic                       nearly_full_reg;
    logic [COUNT_WIDTH-1:0]     drop_count_reg;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       wr_ok;
    logic                       rd_en;

    assign fifo_full  = (occ_reg == OCC_W'(DEPTH));
    assign fifo_empty = (occ_reg == '0);
    // A write into a full FIFO is lost even if a read frees a slot in the same cycle.
    assign wr_ok      = fifo_wr_en & ~fifo_full;
    assign rd_en      = (state_reg == S_IDLE) & ~fifo_empty;

    always_comb begin
        occ_next = occ_reg;
        case ({wr_ok, rd_en})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= fifo_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            nearly_full_reg <= 1'b0;
            drop_count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (fifo_wr_en && fifo_full) begin
                drop_count_reg <= sat_inc(drop_count_reg);
            end
            occ_reg         <= occ_next;
            nearly_full_reg <= (occ_next >= OCC_W'(DEPTH - NEARLY_FULL_MARGIN));
        end
    end

    // ------------------------------------------------------------------
    // Word field decode (valid while in LOAD)
    // ------------------------------------------------------------------
    logic [PKT_TUPLE_WIDTH-1:0] w_tuple;
    logic [PKT_LEN_WIDTH-1:0]   w_len;
    logic [GAP_WIDTH-1:0]       w_gap;
    logic                       w_eot;
    logic                       w_valid;

    assign w_tuple = rd_data_reg[PKT_TUPLE_WIDTH-1:0];
    assign w_len   = rd_data_reg[LEN_LO +: PKT_LEN_WIDTH];
    assign w_gap   = rd_data_reg[GAP_LO +: GAP_WIDTH];
    assign w_eot   = rd_data_reg[EOT_BIT];
    assign w_valid = rd_data_reg[VLD_BIT];

`ifdef TUPLE_LEN_CHECK_EN
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic                   len_bad;
    logic [COUNT_WIDTH-1:0] len_err_count_reg;

    assign len_bad       = (w_len < PKT_LEN_WIDTH'(MIN_LEN)) || (w_len > PKT_LEN_WIDTH'(MAX_LEN));
    assign len_err_count = len_err_count_reg;
`else
    assign len_err_count = '0;
`endif

    // ------------------------------------------------------------------
    // Record sequencer
    // ------------------------------------------------------------------
    logic [PKT_TUPLE_WIDTH-1:0] tuple_reg;
    logic [PKT_LEN_WIDTH-1:0]   len_reg;
    logic [GAP_WIDTH-1:0]       gap_cnt_reg;
    logic                       eot_reg;
    logic                       vld_reg;
    logic                       done_reg;
    logic [COUNT_WIDTH-1:0]     tuple_count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg       <= S_IDLE;
            tuple_reg       <= '0;
            len_reg         <= '0;
            gap_cnt_reg     <= '0;
            eot_reg         <= 1'b0;
            vld_reg         <= 1'b0;
            done_reg        <= 1'b0;
            tuple_count_reg <= '0;
`ifdef TUPLE_LEN_CHECK_EN
            len_err_count_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_valid) begin
                        // Padding word, or a bare end-of-trace marker
                        if (w_eot) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
`ifdef TUPLE_LEN_CHECK_EN
                    else if (len_bad) begin
                        len_err_count_reg <= sat_inc(len_err_count_reg);
                        if (w_eot) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
`endif
                    else begin
                        tuple_reg <= w_tuple;
                        len_reg   <= w_len;
                        eot_reg   <= w_eot;
                        if (w_gap == '0) begin
                            state_reg <= S_PRESENT;
                            vld_reg   <= 1'b1;
                        end else begin
                            gap_cnt_reg <= w_gap;
                            state_reg   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                        state_reg <= S_PRESENT;
                        vld_reg   <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (tuple_out_ready) begin
                        vld_reg         <= 1'b0;
                        tuple_count_reg <= sat_inc(tuple_count_reg);
                        if (eot_reg) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                    vld_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_nearly_full   = nearly_full_reg;
    assign fivetuple_data_out = tuple_reg;
    assign pkt_len_out        = len_reg;
    assign tuple_out_vld      = vld_reg;
    assign replay_done        = done_reg;
    assign tuple_count        = tuple_count_reg;
    assign drop_count         = drop_count_reg;

endmodule

// File: tb/tb_dflow_tuple_unpacker.sv
// Scoreboard bench for dflow_tuple_unpacker: latency, gap pacing, backpressure, overflow,
// end-of-trace, resets and the optional length filter.
module tb_dflow_tuple_unpacker;

    logic         clk;
    logic         rst;
    logic         sw_rst;
    logic         fifo_wr_en;
    logic [143:0] fifo_data;
    logic         fifo_nearly_full;
    logic [103:0] fivetuple_data_out;
    logic [15:0]  pkt_len_out;
    logic         tuple_out_vld;
    logic         tuple_out_ready;
    logic         replay_done;
    logic [31:0]  tuple_count;
    logic [31:0]  drop_count;
    logic [31:0]  len_err_count;

    typedef struct packed {
        logic [103:0] t;
        logic [15:0]  l;
    } rec_t;

    rec_t sb[$];
    int   checks;
    int   errors;
    int   exp_count;

    dflow_tuple_unpacker dut (
        .clk                (clk),
        .rst                (rst),
        .sw_rst             (sw_rst),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_data          (fifo_data),
        .fifo_nearly_full   (fifo_nearly_full),
        .fivetuple_data_out (fivetuple_data_out),
        .pkt_len_out        (pkt_len_out),
        .tuple_out_vld      (tuple_out_vld),
        .tuple_out_ready    (tuple_out_ready),
        .replay_done        (replay_done),
        .tuple_count        (tuple_count),
        .drop_count         (drop_count),
        .len_err_count      (len_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [143:0] mk(input logic [103:0] t, input logic [15:0] l,
                                        input logic [21:0] g, input logic e, input logic v);
        return {v, e, g, l, t};
    endfunction

    task automatic sb_push(input logic [103:0] t, input logic [15:0] l);
        rec_t r;
        r.t = t;
        r.l = l;
        sb.push_back(r);
    endtask

    // Output monitor: every presented record must match the scoreboard head, every cycle.
    always @(negedge clk) begin
        if (tuple_out_vld) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got tuple=%h len=%0d, required no record",
                         fivetuple_data_out, pkt_len_out);
            end else begin
                if (fivetuple_data_out !== sb[0].t || pkt_len_out !== sb[0].l) begin
                    errors++;
                    $display("FAIL record_fields: got tuple=%h len=%0d, required tuple=%h len=%0d",
                             fivetuple_data_out, pkt_len_out, sb[0].t, sb[0].l);
                end
                if (tuple_out_ready) begin
                    $display("record accepted: tuple=%h len=%0d", fivetuple_data_out, pkt_len_out);
                    void'(sb.pop_front());
                    exp_count++;
                end
            end
        end
    end

    task automatic push_word(input logic [143:0] w);
        @(posedge clk);
        #1;
        fifo_data  = w;
        fifo_wr_en = 1'b1;
        @(posedge clk);
        #1;
        fifo_wr_en = 1'b0;
    endtask

    // Counts clock edges from a push until vld is observed; -1 on timeout.
    task automatic wait_vld(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            fifo_wr_en = 1'b0;
            n++;
            @(negedge clk);
            if (tuple_out_vld) return;
        end
        n = -1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d records pending, required 0", name, sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_sw_rst();
        @(posedge clk);
        #1;
        sw_rst = 1'b1;
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        sb.delete();
        exp_count = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tuple_out_vld !== 1'b0 || replay_done !== 1'b0 || fifo_nearly_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got vld=%b done=%b nf=%b, required 0 0 0",
                     tuple_out_vld, replay_done, fifo_nearly_full);
        end
        checks++;
        if (tuple_count !== 32'd0 || drop_count !== 32'd0 || len_err_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d, required 0 0 0",
                     tuple_count, drop_count, len_err_count);
        end
        checks++;
        if (fivetuple_data_out !== 104'd0 || pkt_len_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got tuple=%h len=%0d, required 0 0",
                     fivetuple_data_out, pkt_len_out);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [103:0] t;
        t = {13{8'hA5}};
        tuple_out_ready = 1'b1;
        @(posedge clk);
        #1;
        fifo_data  = mk(t, 16'd64, 22'd0, 1'b0, 1'b1);
        fifo_wr_en = 1'b1;
        sb_push(t, 16'd64);
        wait_vld(40, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required 3", n);
        end
        @(negedge clk);
        checks++;
        if (tuple_count !== 32'd1 || tuple_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got count=%0d vld=%b, required 1 0", tuple_count, tuple_out_vld);
        end
    endtask

    task automatic test_gap();
        int n;
        logic [31:0] cnt0;
        tuple_out_ready = 1'b1;
        @(posedge clk);
        #1;
        fifo_data  = mk(104'h1234_5678, 16'd100, 22'd5, 1'b0, 1'b1);
        fifo_wr_en = 1'b1;
        sb_push(104'h1234_5678, 16'd100);
        wait_vld(40, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL gap_latency: got %0d cycles, required 8", n);
        end
        repeat (3) @(negedge clk);
        cnt0 = 32'(exp_count);
        #1;
        tuple_out_ready = 1'b0;
        @(posedge clk);
        #1;
        fifo_data  = mk(104'hBEEF_0001, 16'd200, 22'd0, 1'b0, 1'b1);
        fifo_wr_en = 1'b1;
        sb_push(104'hBEEF_0001, 16'd200);
        wait_vld(40, n);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (tuple_out_vld !== 1'b1 || tuple_count !== cnt0) begin
                errors++;
                $display("FAIL hold_stall: got vld=%b count=%0d, required 1 %0d",
                         tuple_out_vld, tuple_count, cnt0);
            end
        end
        @(posedge clk);
        #1;
        tuple_out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (tuple_count !== cnt0 + 32'd1 || tuple_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_count: got count=%0d vld=%b, required %0d 0",
                     tuple_count, tuple_out_vld, cnt0 + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        tuple_out_ready = 1'b0;
        @(posedge clk);
        #1;
        fifo_data  = mk(104'hB10C, 16'd300, 22'd0, 1'b0, 1'b1);
        fifo_wr_en = 1'b1;
        sb_push(104'hB10C, 16'd300);
        wait_vld(40, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL blocker_vld: got timeout, required record presented");
        end
        for (int i = 0; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i < 17) begin
                fifo_data  = mk(104'(32'hC000_0000 + i), 16'(500 + i), 22'd0, 1'b0, 1'b1);
                fifo_wr_en = 1'b1;
                if (i < 16) sb_push(104'(32'hC000_0000 + i), 16'(500 + i));
            end else begin
                fifo_wr_en = 1'b0;
            end
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (fifo_nearly_full !== (i >= 12)) begin
                    errors++;
                    $display("FAIL nearly_full_after_%0d_words: got %b, required %b",
                             i, fifo_nearly_full, (i >= 12));
                end
            end
        end
        checks++;
        if (drop_count !== 32'd1) begin
            errors++;
            $display("FAIL overflow_drop_count: got %0d, required 1", drop_count);
        end
        @(posedge clk);
        #1;
        tuple_out_ready = 1'b1;
        wait_drain("overflow", 300);
        checks++;
        if (tuple_count !== 32'(exp_count) || fifo_nearly_full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_final: got count=%0d nf=%b, required %0d 0",
                     tuple_count, fifo_nearly_full, exp_count);
        end
    endtask

    task automatic test_reset_mid_present();
        int n;
        tuple_out_ready = 1'b0;
        @(posedge clk);
        #1;
        fifo_data  = mk(104'hDEAD, 16'd128, 22'd0, 1'b0, 1'b1);
        fifo_wr_en = 1'b1;
        sb_push(104'hDEAD, 16'd128);
        wait_vld(40, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_count = 0;
        tuple_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tuple_out_vld !== 1'b0 || tuple_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_present: got vld=%b count=%0d drop=%0d, required 0 0 0",
                     tuple_out_vld, tuple_count, drop_count);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_eot();
        int n;
        tuple_out_ready = 1'b1;
        push_word(mk(104'h9AD, 16'd64, 22'd0, 1'b0, 1'b0));
        push_word(mk(104'hE0E0, 16'd777, 22'd2, 1'b1, 1'b1));
        sb_push(104'hE0E0, 16'd777);
        wait_drain("eot", 60);
        n = 0;
        while (!replay_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (replay_done !== 1'b1 || tuple_count !== 32'd1) begin
            errors++;
            $display("FAIL eot_done: got done=%b count=%0d, required 1 1", replay_done, tuple_count);
        end
        push_word(mk(104'hAF7E, 16'd99, 22'd0, 1'b0, 1'b1));
        repeat (10) @(negedge clk);
        checks++;
        if (tuple_count !== 32'd1 || replay_done !== 1'b1) begin
            errors++;
            $display("FAIL after_eot: got count=%0d done=%b, required 1 1", tuple_count, replay_done);
        end
        pulse_sw_rst();
        checks++;
        if (replay_done !== 1'b0 || tuple_count !== 32'd0 || tuple_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL sw_rst_clear: got done=%b count=%0d vld=%b, required 0 0 0",
                     replay_done, tuple_count, tuple_out_vld);
        end
        push_word(mk(104'h0, 16'd0, 22'd0, 1'b1, 1'b0));
        repeat (6) @(negedge clk);
        checks++;
        if (replay_done !== 1'b1 || tuple_count !== 32'd0) begin
            errors++;
            $display("FAIL eot_marker: got done=%b count=%0d, required 1 0", replay_done, tuple_count);
        end
        pulse_sw_rst();
    endtask

    task automatic test_len_check();
        logic [15:0] lens [4];
        logic        keep;
        int          exp_err;
        lens[0] = 16'd63;
        lens[1] = 16'd64;
        lens[2] = 16'd1518;
        lens[3] = 16'd1519;
        exp_err = 0;
        tuple_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            keep = 1'b1;
`ifdef TUPLE_LEN_CHECK_EN
            keep = (lens[i] >= 16'd64) && (lens[i] <= 16'd1518);
`endif
            if (keep) sb_push(104'(32'h1E40 + i), lens[i]);
            else exp_err++;
            push_word(mk(104'(32'h1E40 + i), lens[i], 22'd1, 1'b0, 1'b1));
        end
        wait_drain("len", 100);
        repeat (8) @(negedge clk);
        checks++;
        if (len_err_count !== 32'(exp_err)) begin
            errors++;
            $display("FAIL len_err_count: got %0d, required %0d", len_err_count, exp_err);
        end
        checks++;
        if (tuple_count !== 32'(4 - exp_err)) begin
            errors++;
            $display("FAIL len_tuple_count: got %0d, required %0d", tuple_count, 4 - exp_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        exp_count       = 0;
        rst             = 1'b1;
        sw_rst          = 1'b0;
        fifo_wr_en      = 1'b0;
        fifo_data       = '0;
        tuple_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_back_to_back();
        test_reset_mid_present();
        test_eot();
        test_len_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
